mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated word memory serving an instruction fetch port and a data load/store port
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-low reset
//   i_ireq       fetch request (level), i_iaddr fetch byte address, o_idata fetched word
//   i_dbus_re    data read request (level), i_dbus_we data write request (level)
//   i_daddr      data byte address, i_dwdata right-aligned store data
//   i_dsize      0 byte / 1 half / 2 word / 3 illegal, i_dunsigned zero-extend loads
//   o_drdata     extended load result
//   o_stall      freezes the requester while an access is outstanding
//   o_fault      one-cycle pulse on misaligned, out-of-range or illegal-size access
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ireq,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_idata,
    input  logic        i_dbus_re,
    input  logic        i_dbus_we,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dwdata,
    input  logic [1:0]  i_dsize,
    input  logic        i_dunsigned,
    output logic [31:0] o_drdata,
    output logic        o_stall,
    output logic        o_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_wcnt;
    logic        r_isrv;
    logic        r_dsrv;

    // Latched access descriptor
    logic          r_port_d;     // 0 = fetch, 1 = data
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic          r_bad;        // access will report a fault in DONE

    logic [31:0]   r_idata;
    logic [31:0]   r_drdata;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_ipend;
    logic          w_dpend;
    logic          w_pend;
    logic [31:0]   w_sel_addr;
    logic          w_sel_misal;
    logic          w_sel_oor;
    logic          w_exec;
    logic [31:0]   w_rword;
    logic [31:0]   w_lshift;
    logic [31:0]   w_load;
    logic [3:0]    w_bmask;
    logic [31:0]   w_wshift;
    logic [31:0]   w_merged;

    assign w_ipend = i_ireq & ~r_isrv;
    assign w_dpend = (i_dbus_re | i_dbus_we) & ~r_dsrv;
    assign w_pend  = w_ipend | w_dpend;

    // Fetch wins arbitration; the data port simply stays pending.
    assign w_sel_addr  = w_ipend ? i_iaddr : i_daddr;
    assign w_sel_oor   = |w_sel_addr[31:AW+2];
    assign w_sel_misal = ~w_ipend & ((i_dsize == 2'd3) ||
                                     (i_dsize == 2'd1 && i_daddr[0]) ||
                                     (i_dsize == 2'd2 && i_daddr[1:0] != 2'b00));

    assign w_exec  = (r_state == S_BUSY) && (r_wcnt == 4'd0);
    assign w_rword = r_mem[r_idx];

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign w_lshift = w_rword >> {r_lane, 3'b000};
    always_comb begin
        w_load = w_lshift;
        case (r_size)
            2'd0:    w_load = {{24{~r_uns & w_lshift[7]}},  w_lshift[7:0]};
            2'd1:    w_load = {{16{~r_uns & w_lshift[15]}}, w_lshift[15:0]};
            default: w_load = w_lshift;
        endcase
    end

    // Store path: move the data up to its lane and merge only enabled bytes.
    assign w_wshift = r_wdata << {r_lane, 3'b000};
    always_comb begin
        w_bmask = 4'b1111;
        case (r_size)
            2'd0:    w_bmask = 4'b0001 << r_lane;
            2'd1:    w_bmask = 4'b0011 << r_lane;
            default: w_bmask = 4'b1111;
        endcase
    end

    always_comb begin
        w_merged = w_rword;
        for (int b = 0; b < 4; b++) begin
            if (w_bmask[b]) begin
                w_merged[8*b +: 8] = w_wshift[8*b +: 8];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_pend) w_next = w_sel_misal ? S_DONE : S_BUSY;
            S_BUSY: if (r_wcnt == 4'd0) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs. Stall is forced low for the whole time reset is held.
    always_comb begin
        o_stall = 1'b0;
        o_fault = 1'b0;
        if (i_rst) begin
            o_stall = ((r_state == S_IDLE) && w_pend) || (r_state == S_BUSY);
        end
        if (r_state == S_DONE) begin
            o_fault = r_bad;
        end
    end

    // Datapath, counter and served flags
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wcnt   <= 4'd0;
            r_isrv   <= 1'b0;
            r_dsrv   <= 1'b0;
            r_port_d <= 1'b0;
            r_idx    <= '0;
            r_lane   <= 2'd0;
            r_size   <= 2'd0;
            r_uns    <= 1'b0;
            r_wdata  <= 32'd0;
            r_we     <= 1'b0;
            r_bad    <= 1'b0;
            r_idata  <= 32'd0;
            r_drdata <= 32'd0;
        end else begin
            // A served flag only survives while its request stays high, so
            // dropping the request for one cycle re-arms the port.
            if (!i_ireq) begin
                r_isrv <= 1'b0;
            end else if (r_state == S_DONE && !r_port_d) begin
                r_isrv <= 1'b1;
            end
            if (!(i_dbus_re | i_dbus_we)) begin
                r_dsrv <= 1'b0;
            end else if (r_state == S_DONE && r_port_d) begin
                r_dsrv <= 1'b1;
            end

            if (r_state == S_IDLE && w_pend) begin
                r_port_d <= ~w_ipend;
                r_idx    <= w_sel_addr[AW+1:2];
                r_lane   <= w_ipend ? 2'd0 : i_daddr[1:0];
                r_size   <= w_ipend ? 2'd2 : i_dsize;
                r_uns    <= i_dunsigned;
                r_wdata  <= i_dwdata;
                r_we     <= ~w_ipend & i_dbus_we;
                r_bad    <= w_sel_misal | w_sel_oor;
                r_wcnt   <= 4'(WAIT_CYCLES - 1);
                // Misaligned accesses finish right away with a zero result.
                if (w_sel_misal) begin
                    r_drdata <= 32'd0;
                end
            end else if (r_state == S_BUSY && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end

            if (w_exec) begin
                if (!r_port_d) begin
                    r_idata <= r_bad ? 32'd0 : w_rword;
                end else if (r_bad) begin
                    r_drdata <= 32'd0;
                end else if (!r_we) begin
                    r_drdata <= w_load;
                end
            end
        end
    end

    // Storage is not reset; an abandoned access never reaches the execute
    // edge because reset pulls the state out of BUSY immediately.
    always_ff @(posedge i_clk) begin
        if (w_exec && r_we && !r_bad) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    assign o_idata  = r_idata;
    assign o_drdata = r_drdata;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a byte-array model
module tb_mem_responder;

    localparam int DEPTH = 16;
    localparam int WAITC = 2;
    localparam int NBYTES = DEPTH * 4;

    logic        clk;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        dbus_re;
    logic        dbus_we;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [1:0]  dsize;
    logic        dunsigned;
    logic [31:0] drdata;
    logic        stall;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem_b [NBYTES];
    logic [31:0] exp_idata;
    logic [31:0] exp_drdata;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ireq      (ireq),
        .i_iaddr     (iaddr),
        .o_idata     (idata),
        .i_dbus_re   (dbus_re),
        .i_dbus_we   (dbus_we),
        .i_daddr     (daddr),
        .i_dwdata    (dwdata),
        .i_dsize     (dsize),
        .i_dunsigned (dunsigned),
        .o_drdata    (drdata),
        .o_stall     (stall),
        .o_fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_oor(input logic [31:0] a);
        return a >= NBYTES;
    endfunction

    function automatic bit m_misal(input logic [1:0] size, input logic [31:0] a);
        int nb;
        if (size == 2'd3) return 1'b1;
        nb = 1 << size;
        return (a % nb) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
        int nb;
        logic [31:0] v;
        nb = 1 << size;
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
        int nb;
        nb = 1 << size;
        for (int i = 0; i < nb; i++) mem_b[a + i] = wd[8 * i +: 8];
    endtask

    task automatic data_op(input logic we, input logic re, input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
        bit bad;
        bit oor;
        int nst;
        bit done;
        bad = m_misal(size, a);
        oor = m_oor(a);
        @(posedge clk); #1;
        dbus_we = we; dbus_re = re; dsize = size; dunsigned = uns; daddr = a; dwdata = wd;
        nst = 0; done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall) nst++;
            else begin done = 1; break; end
        end
        check_val("d_done", 32'(done), 32'd1);
        check_val("d_stall_cycles", 32'(nst), bad ? 32'd1 : 32'(WAITC + 1));
        check_val("d_fault", 32'(fault), 32'(bad || oor));
        if (bad || oor) exp_drdata = 32'd0;
        else if (we) m_store(a, size, wd);
        else exp_drdata = m_load(a, size, uns);
        if (!we || bad || oor) check_val("d_drdata", drdata, exp_drdata);
        check_val("d_idata_hold", idata, exp_idata);
        @(posedge clk); #1;
        dbus_we = 0; dbus_re = 0;
        @(negedge clk);
        check_val("d_fault_pulse", 32'(fault), 32'd0);
        check_val("d_stall_after", 32'(stall), 32'd0);
    endtask

    task automatic fetch_op(input logic [31:0] a, input int extra);
        int nst;
        bit done;
        bit oor;
        oor = m_oor(a);
        @(posedge clk); #1;
        ireq = 1; iaddr = a;
        nst = 0; done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall) nst++;
            else begin done = 1; break; end
        end
        exp_idata = oor ? 32'd0 : m_load(a & ~32'd3, 2'd2, 1'b1);
        check_val("f_done", 32'(done), 32'd1);
        check_val("f_stall_cycles", 32'(nst), 32'(WAITC + 1));
        check_val("f_fault", 32'(fault), 32'(oor));
        check_val("f_idata", idata, exp_idata);
        check_val("f_drdata_hold", drdata, exp_drdata);
        for (int k = 0; k < extra; k++) begin
            @(negedge clk);
            check_val("f_held_no_stall", 32'(stall), 32'd0);
        end
        @(posedge clk); #1;
        ireq = 0;
        @(negedge clk);
        check_val("f_fault_pulse", 32'(fault), 32'd0);
    endtask

    initial begin
        int nst;
        int ndone;
        int first_done;
        int second_done;
        logic [31:0] fa;
        logic [31:0] da;

        rst = 0; ireq = 0; iaddr = 0; dbus_re = 0; dbus_we = 0;
        daddr = 0; dwdata = 0; dsize = 0; dunsigned = 0;
        exp_idata = 0; exp_drdata = 0;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_fault", 32'(fault), 32'd0);
        check_val("rst_idata", idata, 32'd0);
        check_val("rst_drdata", drdata, 32'd0);
        rst = 1;

        // Give every word a known value
        for (int w = 0; w < DEPTH; w++) data_op(1, 0, 2'd2, 0, 32'(w * 4), $urandom);

        // Fetch after a word store; held request is not re-served
        data_op(1, 0, 2'd2, 0, 32'h10, 32'h0050_0093);
        fetch_op(32'h10, 2);
        check_val("fetch_const", idata, 32'h0050_0093);

        // Byte store into the middle of a word, then loads
        data_op(1, 0, 2'd2, 0, 32'h20, 32'h1122_3344);
        data_op(1, 0, 2'd0, 0, 32'h21, 32'h0000_00AB);
        data_op(0, 1, 2'd2, 0, 32'h20, 0);
        check_val("byte_merge", drdata, 32'h1122_AB44);
        data_op(0, 1, 2'd0, 0, 32'h21, 0);
        check_val("lb_signed", drdata, 32'hFFFF_FFAB);
        data_op(0, 1, 2'd0, 1, 32'h21, 0);
        check_val("lb_unsigned", drdata, 32'h0000_00AB);

        // Misaligned and illegal-size accesses
        data_op(0, 1, 2'd2, 0, 32'h42, 0);
        data_op(1, 0, 2'd2, 0, 32'h22, 32'hDEAD_BEEF);
        data_op(1, 0, 2'd1, 0, 32'h23, 32'h0000_BEEF);
        data_op(1, 0, 2'd3, 0, 32'h20, 32'hDEAD_BEEF);
        data_op(0, 1, 2'd2, 0, 32'h20, 0);
        check_val("misal_no_write", drdata, 32'h1122_AB44);

        // Out of range store and load, then every word must be intact
        data_op(1, 0, 2'd2, 0, 32'h40, 32'hFFFF_FFFF);
        data_op(0, 1, 2'd2, 0, 32'h44, 0);
        fetch_op(32'h80, 0);
        for (int w = 0; w < DEPTH; w++) data_op(0, 1, 2'd2, 0, 32'(w * 4), 0);

        // Simultaneous fetch and data read
        fa = 32'h10; da = 32'h20;
        @(posedge clk); #1;
        ireq = 1; iaddr = fa; dbus_re = 1; dsize = 2'd2; dunsigned = 0; daddr = da;
        nst = 0; ndone = 0; first_done = 0; second_done = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (stall) nst++;
            else begin
                ndone++;
                if (ndone == 1) begin
                    first_done = c;
                    exp_idata = m_load(fa, 2'd2, 1'b1);
                    check_val("dual_fetch_first", idata, exp_idata);
                    check_val("dual_data_pending", drdata, exp_drdata);
                end else begin
                    second_done = c;
                    break;
                end
            end
        end
        exp_drdata = m_load(da, 2'd2, 1'b0);
        check_val("dual_both_done", 32'(ndone), 32'd2);
        check_val("dual_stall_total", 32'(nst), 32'(2 * (WAITC + 1)));
        check_val("dual_gap", 32'(second_done - first_done), 32'(WAITC + 2));
        check_val("dual_drdata", drdata, exp_drdata);
        @(posedge clk); #1;
        ireq = 0; dbus_re = 0;
        @(negedge clk);
        check_val("dual_idle", 32'(stall), 32'd0);

        // Reset in the second BUSY cycle of a store, request dropped
        @(posedge clk); #1;
        dbus_we = 1; dsize = 2'd2; daddr = 32'h14; dwdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 0; #1;
        check_val("rstbusy_stall", 32'(stall), 32'd0);
        dbus_we = 0;
        @(posedge clk); #2;
        check_val("rstbusy_idata", idata, 32'd0);
        check_val("rstbusy_drdata", drdata, 32'd0);
        exp_idata = 0; exp_drdata = 0;
        rst = 1;
        data_op(0, 1, 2'd2, 0, 32'h14, 0);

        // Reset in BUSY with the store held: re-served after release
        @(posedge clk); #1;
        dbus_we = 1; dsize = 2'd2; daddr = 32'h14; dwdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 0; #1;
        check_val("rstheld_stall", 32'(stall), 32'd0);
        @(posedge clk); #2;
        rst = 1;
        exp_idata = 0; exp_drdata = 0;
        nst = 0; ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall) nst++;
            else begin ndone = 1; break; end
        end
        check_val("rstheld_reserved", 32'(nst), 32'(WAITC + 1));
        m_store(32'h14, 2'd2, 32'hCAFE_F00D);
        @(posedge clk); #1;
        dbus_we = 0;
        data_op(0, 1, 2'd2, 0, 32'h14, 0);
        check_val("rstheld_written", drdata, 32'hCAFE_F00D);

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(3) == 0) begin
                fetch_op($urandom_range(NBYTES + 7), 0);
            end else begin
                logic w;
                logic r;
                logic [1:0] sz;
                w = 1'($urandom_range(1));
                r = w ? 1'($urandom_range(1)) : 1'b1;
                sz = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
                data_op(w, r, sz, 1'($urandom_range(1)), $urandom_range(NBYTES + 7), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
